// File: rtl/hdmi_pkg.sv
// Shared HDMI pixel-path types and constants.
package hdmi_pkg;

  localparam int unsigned H_ACTIVE_720P = 1280;
  localparam int unsigned V_ACTIVE_720P = 720;
  localparam int unsigned COMP_W        = 8;
  localparam int unsigned X_W           = 12;
  localparam int unsigned Y_W           = 11;
  localparam int unsigned CNT_W         = 16;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_BARS = 2'd1,
    MODE_GRID = 2'd2,
    MODE_RAMP = 2'd3
  } mode_t;

  typedef struct packed {
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;
  } rgb_t;

  // Colour-bar lookup, left (0) to right (7).
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return rgb_t'(24'hFFFFFF);
      3'd1:    return rgb_t'(24'hFFFF00);
      3'd2:    return rgb_t'(24'h00FFFF);
      3'd3:    return rgb_t'(24'h00FF00);
      3'd4:    return rgb_t'(24'hFF00FF);
      3'd5:    return rgb_t'(24'hFF0000);
      3'd6:    return rgb_t'(24'h0000FF);
      default: return rgb_t'(24'h000000);
    endcase
  endfunction

endpackage

// File: rtl/hdmi_pattern_overlay_if.sv
// Video in/out bundle between the timing stage, the overlay and the ADV7513 pins.
interface hdmi_pattern_overlay_if;
  import hdmi_pkg::*;

  logic              de_i;
  logic              hsync_i;
  logic              vsync_i;
  logic [COMP_W-1:0] r_i;
  logic [COMP_W-1:0] g_i;
  logic [COMP_W-1:0] b_i;
  logic [1:0]        mode_i;

  logic              de_o;
  logic              hsync_o;
  logic              vsync_o;
  logic [COMP_W-1:0] r_o;
  logic [COMP_W-1:0] g_o;
  logic [COMP_W-1:0] b_o;
  logic              line_err_o;
  logic              frame_err_o;
  logic [CNT_W-1:0]  err_cnt_o;

  modport master (
    output de_i, hsync_i, vsync_i, r_i, g_i, b_i, mode_i,
    input  de_o, hsync_o, vsync_o, r_o, g_o, b_o, line_err_o, frame_err_o, err_cnt_o
  );

  modport slave (
    input  de_i, hsync_i, vsync_i, r_i, g_i, b_i, mode_i,
    output de_o, hsync_o, vsync_o, r_o, g_o, b_o, line_err_o, frame_err_o, err_cnt_o
  );

endinterface

// File: rtl/hdmi_pattern_gen.sv
// Stage-2 pattern mux: picks live video or a generated test pattern per pixel.
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_720P,
  parameter int unsigned GRID_LOG2 = 6
) (
  input  logic                 pixel_clk,
  input  logic                 reset_n,
  input  logic                 de_i,
  input  logic [X_W-1:0]       x_i,
  input  logic [GRID_LOG2-1:0] y_i,
  input  mode_t                mode_i,
  input  rgb_t                 rgb_i,
  output rgb_t                 rgb_o
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx_c;
  logic       grid_hit_c;
  rgb_t       rgb_d;
  rgb_t       rgb_q;

  // Bar index from x; positions past the last bar stay on the final (black) bar.
  always_comb begin
    bar_idx_c = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (32'(x_i) >= i * BAR_W) bar_idx_c = 3'(i);
    end
  end

  assign grid_hit_c = (x_i[GRID_LOG2-1:0] == '0) || (y_i == '0);

  // Pattern select; blanking always drives black.
  always_comb begin
    rgb_d = '0;
    if (de_i) begin
      case (mode_i)
        MODE_BARS: rgb_d = bar_colour(bar_idx_c);
        MODE_GRID: rgb_d = grid_hit_c ? rgb_t'(24'hFFFFFF) : rgb_i;
        MODE_RAMP: rgb_d = '{r: x_i[7:0], g: x_i[7:0], b: x_i[7:0]};
        default:   rgb_d = rgb_i;
      endcase
    end
  end

  // Output pixel register.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) rgb_q <= '0;
    else          rgb_q <= rgb_d;
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/hdmi_pattern_overlay.sv
// Pixel-domain overlay: position tracking, test patterns and line/frame geometry checking.
module hdmi_pattern_overlay
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_720P,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_720P,
  parameter int unsigned GRID_LOG2 = 6
) (
  input  logic                   pixel_clk,
  input  logic                   reset_n,
  hdmi_pattern_overlay_if.slave  vid
);

  localparam int unsigned  SUM_W = CNT_W + 1;
  localparam logic [X_W-1:0] X_MAX = '1;
  localparam logic [Y_W-1:0] Y_MAX = '1;

  logic [1:0]           mode_meta_q, mode_sync_q;
  mode_t                mode_q;

  logic                 de_s1_q, hs_s1_q, vs_s1_q;
  rgb_t                 rgb_s1_q;
  rgb_t                 rgb_in_c;
  logic [X_W-1:0]       x_cnt_q, x_cnt_d, pix_x_q;
  logic [Y_W-1:0]       y_cnt_q, y_cnt_d;
  logic [GRID_LOG2-1:0] pix_y_q;
  logic                 armed_q, armed_d;
  logic                 line_err_s1_q, line_err_d;
  logic                 frame_err_s1_q, frame_err_d;

  logic                 de_s2_q, hs_s2_q, vs_s2_q;
  rgb_t                 rgb_s2;
  logic                 line_err_q, frame_err_q;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0]     err_sum_c;

  logic                 de_fall_c, vs_fall_c;

  assign rgb_in_c  = '{r: vid.r_i, g: vid.g_i, b: vid.b_i};
  // Stage-1 registers double as the previous-cycle samples for edge detection.
  assign de_fall_c = ~vid.de_i & de_s1_q;
  assign vs_fall_c = ~vid.vsync_i & vs_s1_q;

  // Mode synchroniser; the pattern only changes at a frame boundary.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_meta_q <= '0;
      mode_sync_q <= '0;
      mode_q      <= MODE_PASS;
    end else begin
      mode_meta_q <= vid.mode_i;
      mode_sync_q <= mode_meta_q;
      if (vs_fall_c) mode_q <= mode_t'(mode_sync_q);
    end
  end

  // Position counters and geometry checks.
  always_comb begin
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    armed_d     = armed_q;
    line_err_d  = 1'b0;
    frame_err_d = 1'b0;

    if (!vid.de_i)             x_cnt_d = '0;
    else if (x_cnt_q != X_MAX) x_cnt_d = x_cnt_q + X_W'(1);

    if (vs_fall_c)                           y_cnt_d = '0;
    else if (de_fall_c && (y_cnt_q != Y_MAX)) y_cnt_d = y_cnt_q + Y_W'(1);

    if (de_fall_c && (x_cnt_q != X_W'(H_ACTIVE))) line_err_d = 1'b1;

    if (vs_fall_c) begin
      armed_d = 1'b1;
      if (armed_q && (y_cnt_q != Y_W'(V_ACTIVE))) frame_err_d = 1'b1;
    end
  end

  // Saturating error counter fed by the stage-1 pulses so it moves with the output pulses.
  always_comb begin
    err_sum_c = {1'b0, err_cnt_q} + SUM_W'(line_err_s1_q) + SUM_W'(frame_err_s1_q);
    err_cnt_d = err_sum_c[CNT_W] ? '1 : err_sum_c[CNT_W-1:0];
  end

  // Stage 1: input capture, pixel position and checker state.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      de_s1_q        <= 1'b0;
      hs_s1_q        <= 1'b1;
      vs_s1_q        <= 1'b1;
      rgb_s1_q       <= '0;
      x_cnt_q        <= '0;
      y_cnt_q        <= '0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      armed_q        <= 1'b0;
      line_err_s1_q  <= 1'b0;
      frame_err_s1_q <= 1'b0;
    end else begin
      de_s1_q        <= vid.de_i;
      hs_s1_q        <= vid.hsync_i;
      vs_s1_q        <= vid.vsync_i;
      rgb_s1_q       <= rgb_in_c;
      x_cnt_q        <= x_cnt_d;
      y_cnt_q        <= y_cnt_d;
      pix_x_q        <= x_cnt_q;
      pix_y_q        <= y_cnt_q[GRID_LOG2-1:0];
      armed_q        <= armed_d;
      line_err_s1_q  <= line_err_d;
      frame_err_s1_q <= frame_err_d;
    end
  end

  // Stage 2: sync/DE delay and error outputs, aligned with the pattern register.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      de_s2_q     <= 1'b0;
      hs_s2_q     <= 1'b1;
      vs_s2_q     <= 1'b1;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      de_s2_q     <= de_s1_q;
      hs_s2_q     <= hs_s1_q;
      vs_s2_q     <= vs_s1_q;
      line_err_q  <= line_err_s1_q;
      frame_err_q <= frame_err_s1_q;
      err_cnt_q   <= err_cnt_d;
    end
  end

  hdmi_pattern_gen #(
    .H_ACTIVE  (H_ACTIVE),
    .GRID_LOG2 (GRID_LOG2)
  ) u_pattern_gen (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .de_i      (de_s1_q),
    .x_i       (pix_x_q),
    .y_i       (pix_y_q),
    .mode_i    (mode_q),
    .rgb_i     (rgb_s1_q),
    .rgb_o     (rgb_s2)
  );

  assign vid.de_o        = de_s2_q;
  assign vid.hsync_o     = hs_s2_q;
  assign vid.vsync_o     = vs_s2_q;
  assign vid.r_o         = rgb_s2.r;
  assign vid.g_o         = rgb_s2.g;
  assign vid.b_o         = rgb_s2.b;
  assign vid.line_err_o  = line_err_q;
  assign vid.frame_err_o = frame_err_q;
  assign vid.err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_hdmi_pattern_overlay.sv
// Scoreboard bench for hdmi_pattern_overlay using 1280-wide lines and short 4-line frames.
module tb_hdmi_pattern_overlay;

  localparam int unsigned H    = 1280;
  localparam int unsigned V    = 4;
  localparam int unsigned GL   = 6;
  localparam int unsigned HS_W = 4;
  localparam int unsigned HBP  = 4;
  localparam int unsigned HFP  = 4;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct {
    logic [23:0] rgb;
    bit          has_hand;
    logic [23:0] hand;
  } exp_t;

  logic pixel_clk = 1'b0;
  logic reset_n   = 1'b1;

  hdmi_pattern_overlay_if vid_if();

  hdmi_pattern_overlay #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .GRID_LOG2 (GL)
  ) dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .vid       (vid_if)
  );

  always #5 pixel_clk = ~pixel_clk;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          exp_line = 0, exp_frame = 0;
  int          obs_line = 0, obs_frame = 0;
  bit          armed_tb = 1'b0;
  int          lines_tb = 0;
  logic [1:0]  mode_eff = 2'd0;
  bit          video_black = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model(input logic [1:0] m, input int x, input int y,
                                         input logic [23:0] live);
    logic [7:0] xl;
    xl = 8'(x);
    case (m)
      2'd1:    model = (x / 160 < 8) ? BARS[x / 160] : 24'h000000;
      2'd2:    model = ((x % 64) == 0 || (y % 64) == 0) ? 24'hFFFFFF : live;
      2'd3:    model = {xl, xl, xl};
      default: model = live;
    endcase
  endfunction

  // Hand-computed spot values at selected pixels.
  task automatic hand_val(input logic [1:0] m, input int x, input int y,
                          output bit has, output logic [23:0] v);
    has = 1'b0;
    v   = 24'h0;
    if (m == 2'd1 && y == 0) begin
      if (x == 0)    begin has = 1'b1; v = 24'hFFFFFF; end
      if (x == 159)  begin has = 1'b1; v = 24'hFFFFFF; end
      if (x == 160)  begin has = 1'b1; v = 24'hFFFF00; end
      if (x == 1279) begin has = 1'b1; v = 24'h000000; end
    end
    if (m == 2'd2 && video_black) begin
      if (x == 5   && y == 0) begin has = 1'b1; v = 24'hFFFFFF; end
      if (x == 64  && y == 1) begin has = 1'b1; v = 24'hFFFFFF; end
      if (x == 128 && y == 2) begin has = 1'b1; v = 24'hFFFFFF; end
      if (x == 65  && y == 1) begin has = 1'b1; v = 24'h000000; end
    end
    if (m == 2'd3 && x == 300) begin has = 1'b1; v = 24'h2C2C2C; end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic idle(input int n);
    vid_if.de_i = 1'b0;
    vid_if.r_i  = '0;
    vid_if.g_i  = '0;
    vid_if.b_i  = '0;
    repeat (n) tick();
  endtask

  task automatic drive_line(input int npx, input int y);
    exp_t        e;
    logic [23:0] live;
    vid_if.hsync_i = 1'b0;
    repeat (HS_W) tick();
    vid_if.hsync_i = 1'b1;
    repeat (HBP) tick();
    for (int x = 0; x < npx; x++) begin
      live = video_black ? 24'h0 : 24'($urandom);
      vid_if.de_i = 1'b1;
      {vid_if.r_i, vid_if.g_i, vid_if.b_i} = live;
      e.rgb = model(mode_eff, x, y, live);
      hand_val(mode_eff, x, y, e.has_hand, e.hand);
      q.push_back(e);
      tick();
    end
    idle(HFP);
    if (npx != int'(H)) exp_line++;
    lines_tb++;
  endtask

  task automatic lines(input int n, input int y0);
    for (int l = 0; l < n; l++) drive_line(H, y0 + l);
  endtask

  task automatic vsync_pulse();
    if (armed_tb && lines_tb != int'(V)) exp_frame++;
    armed_tb = 1'b1;
    lines_tb = 0;
    mode_eff = vid_if.mode_i;
    vid_if.vsync_i = 1'b0;
    repeat (3) tick();
    vid_if.vsync_i = 1'b1;
    repeat (3) tick();
  endtask

  task automatic checkpoint(input string name, input int cnt);
    idle(6);
    chk({name, "_line_pulses"}, 32'(obs_line), 32'(exp_line));
    chk({name, "_frame_pulses"}, 32'(obs_frame), 32'(exp_frame));
    chk({name, "_err_cnt"}, 32'(vid_if.err_cnt_o), 32'(cnt));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_de"}, 32'(vid_if.de_o), 32'h0);
    chk({name, "_hsync"}, 32'(vid_if.hsync_o), 32'h1);
    chk({name, "_vsync"}, 32'(vid_if.vsync_o), 32'h1);
    chk({name, "_rgb"}, 32'({vid_if.r_o, vid_if.g_o, vid_if.b_o}), 32'h0);
    chk({name, "_errs"}, 32'({vid_if.line_err_o, vid_if.frame_err_o}), 32'h0);
    chk({name, "_err_cnt"}, 32'(vid_if.err_cnt_o), 32'h0);
  endtask

  // Monitor: sync delay, scoreboard pops on de_o, error-pulse accounting.
  logic hs_h1 = 1'b1, hs_h2 = 1'b1, vs_h1 = 1'b1, vs_h2 = 1'b1, de_h1 = 1'b0, de_h2 = 1'b0;
  logic prev_de = 1'b0;

  always @(negedge pixel_clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_de = 1'b0;
    end else begin
      chk("hsync_delay", 32'(vid_if.hsync_o), 32'(hs_h2));
      chk("vsync_delay", 32'(vid_if.vsync_o), 32'(vs_h2));
      chk("de_delay", 32'(vid_if.de_o), 32'(de_h2));
      if (vid_if.de_o) begin
        if (q.size() == 0) begin
          chk("unexpected_pixel", 32'h1, 32'h0);
        end else begin
          e = q.pop_front();
          chk("pixel", 32'({vid_if.r_o, vid_if.g_o, vid_if.b_o}), 32'(e.rgb));
          if (e.has_hand)
            chk("spot_pixel", 32'({vid_if.r_o, vid_if.g_o, vid_if.b_o}), 32'(e.hand));
        end
      end else if (prev_de) begin
        chk("blank_rgb", 32'({vid_if.r_o, vid_if.g_o, vid_if.b_o}), 32'h0);
      end
      if (vid_if.line_err_o) begin
        obs_line++;
        chk("line_err_align", 32'({prev_de, vid_if.de_o}), 32'b10);
      end
      if (vid_if.frame_err_o) obs_frame++;
      prev_de = vid_if.de_o;
    end
    hs_h2 = hs_h1; vs_h2 = vs_h1; de_h2 = de_h1;
    hs_h1 = vid_if.hsync_i; vs_h1 = vid_if.vsync_i; de_h1 = vid_if.de_i;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    vid_if.de_i    = 1'b0;
    vid_if.hsync_i = 1'b1;
    vid_if.vsync_i = 1'b1;
    vid_if.r_i     = '0;
    vid_if.g_i     = '0;
    vid_if.b_i     = '0;
    vid_if.mode_i  = 2'd0;
    #2 reset_n = 1'b0;
    repeat (4) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    idle(5);

    // Pass-through with random video.
    vsync_pulse();
    lines(V, 0);

    // Colour bars.
    vid_if.mode_i = 2'd1;
    idle(5);
    vsync_pulse();
    lines(V, 0);

    // Grid over black video.
    vid_if.mode_i = 2'd2;
    video_black = 1'b1;
    idle(5);
    vsync_pulse();
    lines(V, 0);
    video_black = 1'b0;

    // Mode change mid-frame must not take effect until the next frame.
    vid_if.mode_i = 2'd0;
    idle(5);
    vsync_pulse();
    lines(2, 0);
    vid_if.mode_i = 2'd3;
    lines(2, 2);
    idle(5);
    vsync_pulse();
    lines(V, 0);
    vid_if.mode_i = 2'd0;
    checkpoint("clean", 0);

    // One short line.
    vsync_pulse();
    drive_line(H, 0);
    drive_line(H - 1, 1);
    lines(2, 2);
    checkpoint("short_line", 1);

    // Short frame, then an empty frame.
    vsync_pulse();
    lines(V - 1, 0);
    vsync_pulse();
    idle(4);
    checkpoint("short_frame", 2);
    vsync_pulse();
    checkpoint("empty_frame", 3);

    // Reset in the middle of a frame, during blanking.
    lines(2, 0);
    idle(8);
    reset_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("midframe_reset");
    armed_tb  = 1'b0;
    lines_tb  = 0;
    mode_eff  = 2'd0;
    exp_line  = 0;
    exp_frame = 0;
    obs_line  = 0;
    obs_frame = 0;
    reset_n = 1'b1;
    idle(5);
    lines(3, 0);
    vsync_pulse();
    lines(V, 0);
    vsync_pulse();
    checkpoint("after_reset", 0);

    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
